mux_scan_nw: RTL and testbench

//  Parametrised N-channel, W-bit registered multiplexer. Generalises the 2:1 gate-level mux.
//  - Manual mode: the select is driven externally.
//  - Auto-scan mode: an internal counter steps through channels, dwelling DWELL cycles on each.
//  - Exports decode/status probes (one-hot select, error, wrap) for the display/debug logic.

---
 rtl/mux_scan_nw_pkg.sv | 15 +
 rtl/mux_scan_nw_ctrl.sv | 68 ++++++
 rtl/mux_scan_nw.sv | 86 ++++++++
 tb/tb_mux_scan_nw.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_nw_pkg.sv
// Shared mode encodings and default geometry for the scanning N:1 registered mux.
package mux_scan_nw_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  localparam int unsigned DEF_N     = 4;
  localparam int unsigned DEF_W     = 8;
  localparam int unsigned DEF_SW    = 2;
  localparam int unsigned DEF_DWELL = 4;

  // Dwell counter width; DWELL is capped at 255.
  localparam int unsigned DCW = 8;

endpackage

// File: rtl/mux_scan_nw_ctrl.sv
// Stage-1 select register: manual load or auto-scan with a per-channel dwell counter.
module mux_scan_ctrl
  import mux_scan_nw_pkg::*;
#(
  parameter int unsigned N     = DEF_N,
  parameter int unsigned SW    = DEF_SW,
  parameter int unsigned DWELL = DEF_DWELL
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_mode,
  input  logic          i_hold,
  input  logic [SW-1:0] i_sel_in,
  output logic [SW-1:0] o_sel_cur,
  output logic          o_wrap
);

  logic [SW-1:0]  r_sel;
  logic [SW-1:0]  w_sel_nxt;
  logic [DCW-1:0] r_cnt;
  logic [DCW-1:0] w_cnt_nxt;
  logic           r_wrap;
  logic           w_wrap_nxt;
  logic           w_last;
  logic           w_at_top;

  assign w_last   = (r_cnt == DCW'(DWELL - 1));
  // Out-of-range selects also count as "at top" so a scan recovers to channel 0.
  assign w_at_top = (r_sel >= SW'(N - 1));

  always_comb begin
    w_sel_nxt  = r_sel;
    w_cnt_nxt  = r_cnt;
    w_wrap_nxt = 1'b0;
    if (!i_hold) begin
      if (i_mode == MODE_MANUAL) begin
        w_sel_nxt = i_sel_in;
        w_cnt_nxt = '0;
      end else if (!w_last) begin
        w_cnt_nxt = r_cnt + DCW'(1);
      end else begin
        w_cnt_nxt = '0;
        if (w_at_top) begin
          w_sel_nxt  = '0;
          w_wrap_nxt = 1'b1;
        end else begin
          w_sel_nxt = r_sel + SW'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sel  <= '0;
      r_cnt  <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_sel  <= w_sel_nxt;
      r_cnt  <= w_cnt_nxt;
      r_wrap <= w_wrap_nxt;
    end
  end

  assign o_sel_cur = r_sel;
  assign o_wrap    = r_wrap;

endmodule

// File: rtl/mux_scan_nw.sv
// N-channel W-bit registered mux with manual/auto-scan select and decode probes.
module mux_scan_nw
  import mux_scan_nw_pkg::*;
#(
  parameter int unsigned N     = DEF_N,
  parameter int unsigned W     = DEF_W,
  parameter int unsigned SW    = DEF_SW,
  parameter int unsigned DWELL = DEF_DWELL
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_mode,
  input  logic           i_hold,
  input  logic [SW-1:0]  i_sel_in,
  input  logic [N*W-1:0] i_data_in,
  output logic [W-1:0]   o_data_out,
  output logic [SW-1:0]  o_sel_cur,
  output logic [N-1:0]   o_onehot,
  output logic           o_sel_err,
  output logic           o_wrap,
  output logic           o_valid
);

  localparam int unsigned SEW = SW + 1;

  logic [SW-1:0] w_sel_cur;
  logic [W-1:0]  w_data;
  logic [N-1:0]  w_onehot;
  logic          w_sel_err;
  logic [W-1:0]  r_data;
  logic [N-1:0]  r_onehot;
  logic          r_sel_err;
  logic          r_v1;
  logic          r_valid;

  mux_scan_ctrl #(
    .N     (N),
    .SW    (SW),
    .DWELL (DWELL)
  ) u_ctrl (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_mode    (i_mode),
    .i_hold    (i_hold),
    .i_sel_in  (i_sel_in),
    .o_sel_cur (w_sel_cur),
    .o_wrap    (o_wrap)
  );

  // Channel decode; out-of-range selects leave data and one-hot at zero.
  always_comb begin
    w_data   = '0;
    w_onehot = '0;
    for (int k = 0; k < N; k++) begin
      if (w_sel_cur == SW'(k)) begin
        w_data      = i_data_in[k*W +: W];
        w_onehot[k] = 1'b1;
      end
    end
  end

  assign w_sel_err = ({1'b0, w_sel_cur} >= SEW'(N));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data    <= '0;
      r_onehot  <= '0;
      r_sel_err <= 1'b0;
      r_v1      <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      r_data    <= w_data;
      r_onehot  <= w_onehot;
      r_sel_err <= w_sel_err;
      r_v1      <= 1'b1;
      r_valid   <= r_v1;
    end
  end

  assign o_data_out = r_data;
  assign o_sel_cur  = w_sel_cur;
  assign o_onehot   = r_onehot;
  assign o_sel_err  = r_sel_err;
  assign o_valid    = r_valid;

endmodule

// File: tb/tb_mux_scan_nw.sv
// Directed bench: main N=4/DWELL=4 instance, an N=3 instance and a DWELL=1 instance share stimulus.
module tb_mux_scan_nw;

  logic        clk;
  logic        rst;
  logic        mode;
  logic        hold;
  logic [1:0]  sel_in;
  logic [31:0] data_in;

  logic [7:0] a_data;  logic [1:0] a_sel;  logic [3:0] a_oh;  logic a_err, a_wrap, a_valid;
  logic [7:0] b_data;  logic [1:0] b_sel;  logic [2:0] b_oh;  logic b_err, b_wrap, b_valid;
  logic [7:0] c_data;  logic [1:0] c_sel;  logic [3:0] c_oh;  logic c_err, c_wrap, c_valid;

  int compared = 0;
  int mismatched = 0;

  mux_scan_nw #(.N(4), .W(8), .SW(2), .DWELL(4)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_hold(hold), .i_sel_in(sel_in),
    .i_data_in(data_in), .o_data_out(a_data), .o_sel_cur(a_sel), .o_onehot(a_oh),
    .o_sel_err(a_err), .o_wrap(a_wrap), .o_valid(a_valid));

  mux_scan_nw #(.N(3), .W(8), .SW(2), .DWELL(4)) u_dut3 (
    .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_hold(hold), .i_sel_in(sel_in),
    .i_data_in(data_in[23:0]), .o_data_out(b_data), .o_sel_cur(b_sel), .o_onehot(b_oh),
    .o_sel_err(b_err), .o_wrap(b_wrap), .o_valid(b_valid));

  mux_scan_nw #(.N(4), .W(8), .SW(2), .DWELL(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_hold(hold), .i_sel_in(sel_in),
    .i_data_in(data_in), .o_data_out(c_data), .o_sel_cur(c_sel), .o_onehot(c_oh),
    .o_sel_err(c_err), .o_wrap(c_wrap), .o_valid(c_valid));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b0; hold = 1'b0; sel_in = 2'd0; data_in = 32'h0;
    tick(); tick();
    compared++;
    if ({a_data, a_sel, a_oh, a_err, a_wrap, a_valid} !== 17'h0) begin
      $display("FAIL reset_outputs: got %h want 0", {a_data, a_sel, a_oh, a_err, a_wrap, a_valid});
      mismatched++;
    end
  endtask

  task automatic test_manual();
    data_in = 32'h44332211; mode = 1'b0; sel_in = 2'd2; rst = 1'b0;
    tick();
    compared++;
    if (a_sel !== 2'd2) begin $display("FAIL man_sel_1: got %0d want 2", a_sel); mismatched++; end
    compared++;
    if (a_valid !== 1'b0) begin $display("FAIL man_valid_1: got %b want 0", a_valid); mismatched++; end
    tick();
    compared++;
    if (a_data !== 8'h33) begin $display("FAIL man_data: got %h want 33", a_data); mismatched++; end
    compared++;
    if (a_oh !== 4'b0100) begin $display("FAIL man_onehot: got %b want 0100", a_oh); mismatched++; end
    compared++;
    if (a_valid !== 1'b1 || a_err !== 1'b0) begin
      $display("FAIL man_valid_err: got %b%b want 10", a_valid, a_err); mismatched++;
    end
  endtask

  task automatic test_scan();
    logic [1:0] exp_sel;
    logic       exp_wrap;
    sel_in = 2'd0;
    tick();
    mode = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      exp_sel  = 2'((k / 4) % 4);
      exp_wrap = (k == 16);
      compared++;
      if (a_sel !== exp_sel || a_wrap !== exp_wrap) begin
        $display("FAIL scan_step%0d: got sel=%0d wrap=%b want sel=%0d wrap=%b",
                 k, a_sel, a_wrap, exp_sel, exp_wrap);
        mismatched++;
      end
    end
  endtask

  task automatic test_hold();
    logic [7:0] exp_data;
    tick(); tick();
    compared++;
    if (a_sel !== 2'd0) begin $display("FAIL hold_pre_sel: got %0d want 0", a_sel); mismatched++; end
    hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) data_in = 32'hd4c3b2a1;
      tick();
      exp_data = (i >= 4) ? 8'ha1 : 8'h11;
      compared++;
      if (a_sel !== 2'd0 || a_wrap !== 1'b0 || a_data !== exp_data) begin
        $display("FAIL hold_cyc%0d: got sel=%0d wrap=%b data=%h want sel=0 wrap=0 data=%h",
                 i, a_sel, a_wrap, a_data, exp_data);
        mismatched++;
      end
    end
    hold = 1'b0;
    tick();
    compared++;
    if (a_sel !== 2'd0) begin $display("FAIL hold_resume1: got %0d want 0", a_sel); mismatched++; end
    tick();
    compared++;
    if (a_sel !== 2'd1) begin $display("FAIL hold_resume2: got %0d want 1", a_sel); mismatched++; end
    hold = 1'b1; mode = 1'b0; sel_in = 2'd3;
    tick(); tick(); tick();
    compared++;
    if (a_sel !== 2'd1) begin $display("FAIL hold_mode_frozen: got %0d want 1", a_sel); mismatched++; end
    hold = 1'b0;
    tick();
    compared++;
    if (a_sel !== 2'd3) begin $display("FAIL hold_mode_release: got %0d want 3", a_sel); mismatched++; end
    tick();
    compared++;
    if (a_data !== 8'hd4 || a_oh !== 4'b1000) begin
      $display("FAIL hold_mode_data: got %h/%b want d4/1000", a_data, a_oh); mismatched++;
    end
  endtask

  task automatic test_out_of_range();
    mode = 1'b0; sel_in = 2'd3;
    tick(); tick();
    compared++;
    if (b_sel !== 2'd3 || b_data !== 8'h00 || b_oh !== 3'b000 || b_err !== 1'b1) begin
      $display("FAIL oor_manual: got sel=%0d data=%h oh=%b err=%b want 3/00/000/1",
               b_sel, b_data, b_oh, b_err);
      mismatched++;
    end
    mode = 1'b1;
    tick(); tick(); tick();
    compared++;
    if (b_sel !== 2'd3 || b_wrap !== 1'b0) begin
      $display("FAIL oor_dwell: got sel=%0d wrap=%b want 3/0", b_sel, b_wrap); mismatched++;
    end
    tick();
    compared++;
    if (b_sel !== 2'd0 || b_wrap !== 1'b1) begin
      $display("FAIL oor_wrap: got sel=%0d wrap=%b want 0/1", b_sel, b_wrap); mismatched++;
    end
    tick();
    compared++;
    if (b_err !== 1'b0 || b_data !== 8'ha1 || b_wrap !== 1'b0) begin
      $display("FAIL oor_recover: got err=%b data=%h wrap=%b want 0/a1/0", b_err, b_data, b_wrap);
      mismatched++;
    end
  endtask

  task automatic test_reset_mid_scan();
    mode = 1'b0; sel_in = 2'd2;
    tick();
    mode = 1'b1;
    tick(); tick();
    compared++;
    if (a_sel !== 2'd2 || a_valid !== 1'b1) begin
      $display("FAIL rst_pre: got sel=%0d valid=%b want 2/1", a_sel, a_valid); mismatched++;
    end
    rst = 1'b1;
    tick();
    compared++;
    if ({a_data, a_sel, a_oh, a_err, a_wrap, a_valid} !== 17'h0) begin
      $display("FAIL rst_mid: got %h want 0", {a_data, a_sel, a_oh, a_err, a_wrap, a_valid});
      mismatched++;
    end
    rst = 1'b0; mode = 1'b0; sel_in = 2'd0;
    tick();
    compared++;
    if (a_valid !== 1'b0) begin $display("FAIL rst_valid1: got %b want 0", a_valid); mismatched++; end
    tick();
    compared++;
    if (a_valid !== 1'b1) begin $display("FAIL rst_valid2: got %b want 1", a_valid); mismatched++; end
  endtask

  task automatic test_dwell1();
    logic [1:0] exp_sel;
    mode = 1'b0; sel_in = 2'd0;
    tick();
    mode = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_sel = 2'(k % 4);
      compared++;
      if (c_sel !== exp_sel || c_wrap !== (k % 4 == 0)) begin
        $display("FAIL dwell1_step%0d: got sel=%0d wrap=%b want sel=%0d wrap=%b",
                 k, c_sel, c_wrap, exp_sel, (k % 4 == 0));
        mismatched++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_scan();
    test_hold();
    test_out_of_range();
    test_reset_mid_scan();
    test_dwell1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
